instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  DATA_WIDTH  byte address of requested word.
REQ-007 imem_ready  input  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1.
REQ-008 imem_rdata  input  DATA_WIDTH  fetched instruction word.
REQ-009 instr_valid  output  1  instr/instr_pc/opcode hold a valid instruction for decode.
REQ-010 instr  output  DATA_WIDTH  registered instruction word.
REQ-011 instr_pc  output  DATA_WIDTH  address instr was fetched from.
REQ-012 opcode  output  7  instr[6:0], feeds control unit opcode input.
REQ-013 dec_ready  input  1  decode accepts instruction; transfer = instr_valid & dec_ready.
REQ-014 redirect_valid  input  1  taken branch/jump; replace fetch PC.
REQ-015 redirect_pc  input  DATA_WIDTH  redirect target byte address.
REQ-016 misaligned  output  1  one-cycle pulse: redirect_pc[1:0] != 0 accepted.

Function
REQ-017 Internal PC register SHALL hold next fetch address; pc[1:0] always 0.
REQ-018 FSM states SHALL be FETCH, HOLD, DROP; encoding free.
REQ-019 FETCH: imem_req=1, imem_addr=pc; on imem_ready: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^DATA_WIDTH, wraps to 0), next HOLD.
REQ-020 FETCH without imem_ready: stay FETCH, imem_addr held stable.
REQ-021 HOLD: imem_req=0; instr/instr_pc stable while instr_valid=1 and dec_ready=0.
REQ-022 HOLD with dec_ready=1: instr_valid<=0, next FETCH; minimum issue interval 2 cycles with zero-wait memory.
REQ-023 Redirect has priority over all other events in every state; pc<={redirect_pc[DATA_WIDTH-1:2],2'b00}, instr_valid<=0.
REQ-024 Redirect in HOLD or in FETCH coincident with imem_ready: fetched/held word discarded, next FETCH.
REQ-025 Redirect in FETCH without imem_ready: next DROP (request outstanding, address must not change).
REQ-026 DROP: imem_req=1, imem_addr=address of outstanding request; on imem_ready word discarded, instr_valid stays 0, next FETCH at redirected pc.
REQ-027 Redirect in DROP: pc updated to newest target, remain DROP until imem_ready.
REQ-028 misaligned SHALL pulse 1 cycle after any accepted redirect with redirect_pc[1:0]!=0; otherwise 0.
REQ-029 opcode SHALL be combinational slice of instr register; no other combinational path from inputs to outputs except none (imem_req, imem_addr from state/registers only).
REQ-030 Redirect concurrent with transfer (HOLD, dec_ready=1): transfer counts as consumed; redirect applied.

Reset
REQ-031 reset=1 on a clock edge SHALL force: state FETCH, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misaligned=0.
REQ-032 Reset mid-request SHALL abandon outstanding fetch; memory must tolerate dropped req (responses during reset ignored).
REQ-033 First cycle after reset deassert: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-034 Reset, zero-wait memory returning addr-as-data, dec_ready=1 -> instr_pc sequence 0,4,8,C, each instr_valid for 1 cycle, 2-cycle spacing.
REQ-035 imem_ready delayed 3 cycles at addr 0x10 -> imem_addr stays 0x10 for 4 cycles, single capture, pc becomes 0x14.
REQ-036 dec_ready=0 for 5 cycles with instr 0x00500093 valid -> instr/instr_pc/opcode (0x13) stable, imem_req=0 throughout.
REQ-037 Redirect to 0x200 during FETCH with memory 2-cycle wait -> DROP, stale word discarded, next imem_addr=0x200, no instr_valid for stale word.
REQ-038 Redirect to 0x103 -> misaligned pulse 1 cycle, next fetch address 0x100; reset asserted while waiting -> next fetch RESET_PC.
REQ-039 pc=0xFFFF_FFFC fetch -> next imem_addr 0x0000_0000.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Single-outstanding-request instruction fetch stage. Issues
//               word fetches to instruction memory, registers the returned
//               word for decode, and handles branch/jump redirects. When a
//               redirect arrives while a request is still pending, the
//               pending response is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [6:0]            opcode,
    input  logic                  dec_ready,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  misaligned
);

    // FETCH: request outstanding at r_pc
    // HOLD : instruction waiting for decode, no request
    // DROP : request outstanding at r_drop_addr whose response is discarded
    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_hold  = 2'd1;
    localparam logic [1:0] c_st_drop  = 2'd2;

    localparam logic [DATA_WIDTH-1:0] c_pc_step     = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_reset_pc_al = {RESET_PC[DATA_WIDTH-1:2], 2'b00};

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_drop_addr;
    logic                  r_instr_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_instr_pc;
    logic                  r_misaligned;
    logic [DATA_WIDTH-1:0] w_redirect_al;

    // Redirect targets are forced to word alignment; low bits only flag misalignment.
    assign w_redirect_al = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; redirect takes priority except that an outstanding
    // request must still be retired before a new address can be issued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_fetch: begin
                if (redirect_valid) begin
                    w_state_next = imem_ready ? c_st_fetch : c_st_drop;
                end else if (imem_ready) begin
                    w_state_next = c_st_hold;
                end
            end
            c_st_hold: begin
                if (redirect_valid || dec_ready) begin
                    w_state_next = c_st_fetch;
                end
            end
            c_st_drop: begin
                if (imem_ready) begin
                    w_state_next = c_st_fetch;
                end
            end
            default: w_state_next = c_st_fetch;
        endcase
    end

    // PC, captured instruction and pending-drop address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= c_reset_pc_al;
            r_drop_addr   <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else if (redirect_valid) begin
            r_pc          <= w_redirect_al;
            r_instr_valid <= 1'b0;
            // Only a still-pending FETCH request needs its address remembered;
            // in DROP the original outstanding address is kept.
            if (r_state == c_st_fetch && !imem_ready) begin
                r_drop_addr <= r_pc;
            end
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (imem_ready) begin
                        r_instr       <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_pc          <= r_pc + c_pc_step;
                    end
                end
                c_st_hold: begin
                    if (dec_ready) begin
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One-cycle flag for a redirect target that was not word aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign imem_req    = (r_state != c_st_hold);
    assign imem_addr   = (r_state == c_st_drop) ? r_drop_addr : r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[6:0];
    assign misaligned  = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed, table-driven bench for instruction_fetch. Each
//               table row gives the inputs for one clock edge and the outputs
//               expected just after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned;

    int r_total;
    int r_passed;

    instruction_fetch #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] rdata;
        logic        drdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    localparam int c_num_vec = 37;
    vec_t vecs [c_num_vec];

    function automatic vec_t mk(
        input logic rst, input logic rdy, input logic [31:0] rdata,
        input logic drdy, input logic rv, input logic [31:0] rpc,
        input logic e_req, input logic [31:0] e_addr, input logic e_v,
        input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_mis);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.drdy = drdy;
        v.rv = rv; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_v = e_v; v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        r_total++;
        if (act === exp) begin
            r_passed++;
        end else begin
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset          = v.rst;
        imem_ready     = v.rdy;
        imem_rdata     = v.rdata;
        dec_ready      = v.drdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input vec_t v, input int idx);
        logic [31:0] exp_instr;
        exp_instr = v.e_instr;
        check("imem_req",    idx, {31'd0, imem_req},    {31'd0, v.e_req});
        check("imem_addr",   idx, imem_addr,            v.e_addr);
        check("instr_valid", idx, {31'd0, instr_valid}, {31'd0, v.e_v});
        check("instr",       idx, instr,                v.e_instr);
        check("instr_pc",    idx, instr_pc,             v.e_ipc);
        check("opcode",      idx, {25'd0, opcode},      {25'd0, exp_instr[6:0]});
        check("misaligned",  idx, {31'd0, misaligned},  {31'd0, v.e_mis});
    endtask

    initial begin
        vec_t v;
        r_total  = 0;
        r_passed = 0;
        reset          = 1'b1;
        imem_ready     = 1'b0;
        imem_rdata     = '0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        //                rst rdy rdata          drdy rv rpc            req addr           v  instr          ipc            mis
        // reset state
        vecs[0]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          32'h0,          0);
        vecs[1]  = mk(1, 1, 32'hFFFF_FFFF,  1, 1, 32'h3,          1, 32'h0000_0000, 0, 32'h0,          32'h0,          0);
        // zero-wait memory returning address as data, decode always ready
        vecs[2]  = mk(0, 1, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0004, 1, 32'h0,          32'h0,          0);
        vecs[3]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0004, 0, 32'h0,          32'h0,          0);
        vecs[4]  = mk(0, 1, 32'h4,          1, 0, 32'h0,          0, 32'h0000_0008, 1, 32'h4,          32'h4,          0);
        vecs[5]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0008, 0, 32'h4,          32'h4,          0);
        vecs[6]  = mk(0, 1, 32'h8,          1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h8,          32'h8,          0);
        vecs[7]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_000C, 0, 32'h8,          32'h8,          0);
        vecs[8]  = mk(0, 1, 32'hC,          1, 0, 32'h0,          0, 32'h0000_0010, 1, 32'hC,          32'hC,          0);
        vecs[9]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0010, 0, 32'hC,          32'hC,          0);
        // three wait cycles at 0x10, address held
        vecs[10] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0010, 0, 32'hC,          32'hC,          0);
        vecs[11] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0010, 0, 32'hC,          32'hC,          0);
        vecs[12] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0010, 0, 32'hC,          32'hC,          0);
        vecs[13] = mk(0, 1, 32'h0050_0093,  0, 0, 32'h0,          0, 32'h0000_0014, 1, 32'h0050_0093,  32'h10,         0);
        // decode stalled five cycles; stray ready/data while no request ignored
        vecs[14] = mk(0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,          0, 32'h0000_0014, 1, 32'h0050_0093,  32'h10,         0);
        vecs[15] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0000_0014, 1, 32'h0050_0093,  32'h10,         0);
        vecs[16] = mk(0, 1, 32'h1111_1111,  0, 0, 32'h0,          0, 32'h0000_0014, 1, 32'h0050_0093,  32'h10,         0);
        vecs[17] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0000_0014, 1, 32'h0050_0093,  32'h10,         0);
        vecs[18] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0000_0014, 1, 32'h0050_0093,  32'h10,         0);
        vecs[19] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0014, 0, 32'h0050_0093,  32'h10,         0);
        // redirect to 0x200 while the 0x14 request waits two cycles
        vecs[20] = mk(0, 0, 32'h0,          1, 1, 32'h200,        1, 32'h0000_0014, 0, 32'h0050_0093,  32'h10,         0);
        vecs[21] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0014, 0, 32'h0050_0093,  32'h10,         0);
        vecs[22] = mk(0, 1, 32'hBAD0_BAD0,  1, 0, 32'h0,          1, 32'h0000_0200, 0, 32'h0050_0093,  32'h10,         0);
        vecs[23] = mk(0, 1, 32'h200,        0, 0, 32'h0,          0, 32'h0000_0204, 1, 32'h200,        32'h200,        0);
        // redirect coincident with a transfer out of HOLD
        vecs[24] = mk(0, 0, 32'h0,          1, 1, 32'h300,        1, 32'h0000_0300, 0, 32'h200,        32'h200,        0);
        // misaligned redirect coincident with ready: word discarded
        vecs[25] = mk(0, 1, 32'h300,        1, 1, 32'h103,        1, 32'h0000_0100, 0, 32'h200,        32'h200,        1);
        vecs[26] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0100, 0, 32'h200,        32'h200,        0);
        vecs[27] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0100, 0, 32'h200,        32'h200,        0);
        // reset while waiting; response during reset ignored
        vecs[28] = mk(1, 1, 32'h55,         1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          32'h0,          0);
        vecs[29] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          32'h0,          0);
        // redirects while in DROP: newest target wins
        vecs[30] = mk(0, 0, 32'h0,          1, 1, 32'h40,         1, 32'h0000_0000, 0, 32'h0,          32'h0,          0);
        vecs[31] = mk(0, 0, 32'h0,          1, 1, 32'h81,         1, 32'h0000_0000, 0, 32'h0,          32'h0,          1);
        vecs[32] = mk(0, 1, 32'h1234,       1, 0, 32'h0,          1, 32'h0000_0080, 0, 32'h0,          32'h0,          0);
        vecs[33] = mk(0, 1, 32'h80,         0, 0, 32'h0,          0, 32'h0000_0084, 1, 32'h80,         32'h80,         0);
        // redirect in HOLD while decode stalled
        vecs[34] = mk(0, 0, 32'h0,          0, 1, 32'h20,         1, 32'h0000_0020, 0, 32'h80,         32'h80,         0);
        // redirect in DROP coincident with the outstanding response
        vecs[35] = mk(0, 0, 32'h0,          1, 1, 32'h60,         1, 32'h0000_0020, 0, 32'h80,         32'h80,         0);
        vecs[36] = mk(0, 1, 32'h9999,       1, 1, 32'h70,         1, 32'h0000_0070, 0, 32'h80,         32'h80,         0);

        for (int i = 0; i < c_num_vec; i++) begin
            drive(vecs[i]);
            check_all(vecs[i], i);
        end

        // PC wrap: fetch from 0xFFFF_FFFC, next address wraps to zero
        v = mk(0, 1, 32'h0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h80, 32'h80, 0);
        drive(v);
        check_all(v, 100);
        v = mk(0, 1, 32'h0000_0013, 0, 0, 32'h0, 0, 32'h0000_0000, 1, 32'h0000_0013, 32'hFFFF_FFFC, 0);
        drive(v);
        check_all(v, 101);
        v = mk(0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_0000, 0, 32'h0000_0013, 32'hFFFF_FFFC, 0);
        drive(v);
        check_all(v, 102);

        // Issue spacing with a zero-wait memory: count valid cycles in a window
        begin
            int n_valid;
            n_valid = 0;
            @(negedge clk);
            dec_ready      = 1'b1;
            redirect_valid = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                imem_ready = imem_req;
                imem_rdata = imem_addr;
                @(posedge clk);
                #1;
                if (instr_valid) begin
                    n_valid++;
                    check("stream_data", 200 + c, instr, instr_pc);
                end
            end
            check("issue_count", 300, n_valid, 6);
        end

        $display("%0d/%0d checks passed", r_passed, r_total);
        $finish;
    end

endmodule
`default_nettype wire
